ddr_app_wr_packer: RTL and testbench
====================================

// Module: ddr_app_wr_packer
// PURPOSE
// - Write-path stage between the 128-bit din/wr_en user stream and the DDR4 MIG native app interface, clocked by ui_clk.
// - Packs 4 x 128-bit beats into one 512-bit MIG word and buffers words in a small FIFO.
// - Issues each buffered word as a write command at incrementing addresses once c0_init_calib_complete is high.
// PARAMETERS
// - ADDR_W      28  app_addr width
// - ADDR_STEP   8   address increment per 512-bit word (BL8, x64)
// - FIFO_DEPTH  4   512-bit word buffer depth (power of 2, >=2)
// PORTS
// - ui_clk                  in   1    single clock for all logic
// - rst_n                   in   1    asynchronous, active-low reset
// - din                     in   128  user data beat
// - wr_en                   in   1    beat valid; accepted when din_full==0
// - flush                   in   1    1-cycle pulse; emits a partially filled word, masked
// - din_full                out  1    back-pressure: next beat cannot be accepted
// - c0_init_calib_complete  in   1    MIG calibration done
// - app_en/app_cmd          out  1/3  command valid / command (always 3'b000 write)
// - app_addr                out  ADDR_W  command address
// - app_rdy                 in   1    MIG command accept
// - app_wdf_data            out  512  write data; beat0 in [127:0] ... beat3 in [511:384]
// - app_wdf_mask            out  64   byte mask, 1 = byte not written
// - app_wdf_wren/app_wdf_end out 1/1  data valid / last (app_wdf_end == app_wdf_wren)
// - app_wdf_rdy             in   1    MIG data accept
// - words_written           out  32   count of completed word writes
// - overflow                out  1    sticky: wr_en while din_full
// BEHAVIOUR
// - Reset (async, rst_n=0): all outputs 0; beat_cnt=0; FIFO empty; addr=0; counters and flags cleared; FSM to WAIT_CAL.
// - Reset mid-burst aborts the burst; partially packed and buffered data are discarded.
// - Packer: beat_cnt 0..3. On an accepted beat, the beat is stored at slot beat_cnt.
//   - At beat_cnt==3 the word is pushed into the FIFO with mask=0 and beat_cnt wraps to 0.
// - Flush with beat_cnt>0: pushes the word with unused slots zero-filled and their bytes masked.
//   - Mask is 16 bits per unfilled slot; e.g. 2 beats -> 64'hFFFFFFFF_00000000.
// - Flush with beat_cnt==0: no-op.
// - Flush in the same cycle as wr_en: the beat is included first, then the word is pushed.
// - A 4th beat arriving with flush is a normal full push.
// - din_full = fifo_full & (beat_cnt==3 | flush-pending). It is combinational from registered state and excludes a same-cycle pop.
// - wr_en while din_full: the beat is dropped and overflow is set (sticky until reset).
// - FSM WAIT_CAL: app_en=0, app_wdf_wren=0. The FIFO still fills. Go to IDLE when c0_init_calib_complete=1.
// - FSM IDLE: when the FIFO is non-empty -> ISSUE (registered, 1-cycle latency head->app_en).
// - FSM ISSUE: present the FIFO head and assert app_en and app_wdf_wren together.
//   - app_en drops after the cycle with app_en&app_rdy; app_wdf_wren drops after the cycle with app_wdf_wren&app_wdf_rdy.
//   - The two acks may arrive in either order or in the same cycle.
//   - When both are done: pop the FIFO, addr += ADDR_STEP (wraps modulo 2^ADDR_W), and words_written++ (wraps at 2^32).
//   - Then go back-to-back to ISSUE if the FIFO is non-empty, else to IDLE.
// - Calibration drop (c0_init_calib_complete=0) in IDLE -> WAIT_CAL. In ISSUE, the current word completes first.
// - app_addr, data and mask stay stable while app_en or app_wdf_wren is high.
// CONFIGURATION
// - DDR_WR_PERF_CNT_EN defined: adds outputs stall_cmd_cycles[31:0] and stall_data_cycles[31:0].
//   - stall_cmd_cycles counts cycles with app_en & ~app_rdy; stall_data_cycles counts cycles with app_wdf_wren & ~app_wdf_rdy.
//   - Both saturate at 32'hFFFFFFFF and are cleared by reset.
// - DDR_WR_PERF_CNT_EN undefined: ports and logic absent; all other behaviour is identical.
// TESTING
// - Calib held low for 200 cycles, 8 beats pushed -> app_en stays 0; 2 words buffered; after calib rises, addrs 0 then 8 are issued.
// - Ramp din=1..500 with app_rdy=app_wdf_rdy=1 -> 125 words at addrs 0..992; word0 data = {128'd4,128'd3,128'd2,128'd1}; words_written=125.
// - 6 beats then flush -> 2 words; word1 mask = 64'hFFFFFFFF_00000000 and upper 256 bits = 0.
// - app_rdy low for 10 cycles while app_wdf_rdy=1 (then swapped) -> single pop per word, data held stable, no duplicate writes.
// - app_rdy=0 continuously, 24 beats pushed (FIFO_DEPTH=4) -> din_full asserts after beat 19; beat 20 dropped with overflow=1.
// - rst_n pulsed low mid-ISSUE -> outputs 0 immediately; after release, addr restarts at 0 and words_written=0.

Source files
------------

// File: rtl/ddr_app_wr_packer_if.sv
// MIG native app write interface: command channel plus write-data channel.
// master = packer side, slave = memory controller side.
interface ddr_app_wr_packer_if #(
    parameter int ADDR_W = 28
);
    logic              app_en;
    logic [2:0]        app_cmd;
    logic [ADDR_W-1:0] app_addr;
    logic              app_rdy;
    logic [511:0]      app_wdf_data;
    logic [63:0]       app_wdf_mask;
    logic              app_wdf_wren;
    logic              app_wdf_end;
    logic              app_wdf_rdy;

    modport master (
        output app_en, app_cmd, app_addr, app_wdf_data, app_wdf_mask,
               app_wdf_wren, app_wdf_end,
        input  app_rdy, app_wdf_rdy
    );

    modport slave (
        input  app_en, app_cmd, app_addr, app_wdf_data, app_wdf_mask,
               app_wdf_wren, app_wdf_end,
        output app_rdy, app_wdf_rdy
    );
endinterface

// File: rtl/ddr_app_wr_packer.sv
// Packs 4 x 128-bit beats into 512-bit MIG words, buffers them and issues writes.
// Optional stall counters: define DDR_WR_PERF_CNT_EN.
module ddr_app_wr_packer #(
    parameter int ADDR_W     = 28,
    parameter int ADDR_STEP  = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 ui_clk,
    input  logic                 rst_n,
    input  logic [127:0]         din,
    input  logic                 wr_en,
    input  logic                 flush,
    output logic                 din_full,
    input  logic                 c0_init_calib_complete,
    ddr_app_wr_packer_if.master  app,
    output logic [31:0]          words_written,
    output logic                 overflow
`ifdef DDR_WR_PERF_CNT_EN
    ,
    output logic [31:0]          stall_cmd_cycles,
    output logic [31:0]          stall_data_cycles
`endif
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {WAIT_CAL, IDLE, ISSUE} state_t;

    state_t            state;
    logic [1:0]        beat_cnt;
    logic [127:0]      slot_q [4];
    logic              flush_pend;
    logic [511:0]      fifo_data [FIFO_DEPTH];
    logic [63:0]       fifo_mask [FIFO_DEPTH];
    logic [PTR_W:0]    wr_ptr;
    logic [PTR_W:0]    rd_ptr;
    logic [PTR_W:0]    fifo_count;
    logic              fifo_full;
    logic              fifo_empty;
    logic              accept;
    logic              flush_req;
    logic [2:0]        fill_cnt;
    logic              push_full;
    logic              push;
    logic [511:0]      push_data;
    logic [63:0]       push_mask;
    logic [PTR_W-1:0]  head_idx;
    logic [PTR_W-1:0]  next_idx;
    logic              word_done;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_next;

    assign fifo_count = wr_ptr - rd_ptr;
    assign fifo_full  = (fifo_count == (PTR_W+1)'(FIFO_DEPTH));
    assign fifo_empty = (wr_ptr == rd_ptr);

    // A same-cycle pop is deliberately ignored so din_full depends only on state.
    assign din_full  = fifo_full & ((beat_cnt == 2'd3) | flush_pend);
    assign accept    = wr_en & ~din_full;
    assign flush_req = flush | flush_pend;
    assign fill_cnt  = {1'b0, beat_cnt} + {2'b00, accept};
    assign push_full = accept & (beat_cnt == 2'd3);
    assign push      = push_full | (flush_req & (fill_cnt != 3'd0) & ~fifo_full);

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        push_data = '0;
        push_mask = '1;
        for (int i = 0; i < 4; i++) begin
            if (3'(i) < fill_cnt) begin
                push_data[i*128 +: 128] = (accept && beat_cnt == 2'(i)) ? din : slot_q[i];
                push_mask[i*16 +: 16]   = '0;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge ui_clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt   <= '0;
            flush_pend <= 1'b0;
            overflow   <= 1'b0;
            wr_ptr     <= '0;
        end else begin
            if (wr_en && din_full)
                overflow <= 1'b1;
            if (push)
                beat_cnt <= '0;
            else if (accept)
                beat_cnt <= beat_cnt + 2'd1;
            // A flush that finds the FIFO full waits here until space opens.
            flush_pend <= flush_req & ~push & (fill_cnt != 3'd0);
            if (push)
                wr_ptr <= wr_ptr + (PTR_W+1)'(1);
        end
    end

    // NOTE: data storage carries no reset; pointers and beat_cnt define validity.
    always_ff @(posedge ui_clk) begin
        if (accept)
            slot_q[beat_cnt] <= din;
        if (push) begin
            fifo_data[wr_ptr[PTR_W-1:0]] <= push_data;
            fifo_mask[wr_ptr[PTR_W-1:0]] <= push_mask;
        end
    end

    assign head_idx  = rd_ptr[PTR_W-1:0];
    assign next_idx  = head_idx + PTR_W'(1);
    assign addr_next = addr_q + ADDR_W'(ADDR_STEP);
    assign word_done = (state == ISSUE)
                     & (~app.app_en | app.app_rdy)
                     & (~app.app_wdf_wren | app.app_wdf_rdy);

    assign app.app_cmd     = 3'b000;
    assign app.app_wdf_end = app.app_wdf_wren;

    always_ff @(posedge ui_clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= WAIT_CAL;
            app.app_en       <= 1'b0;
            app.app_wdf_wren <= 1'b0;
            app.app_addr     <= '0;
            app.app_wdf_data <= '0;
            app.app_wdf_mask <= '0;
            addr_q           <= '0;
            words_written    <= '0;
            rd_ptr           <= '0;
        end else begin
            case (state)
                WAIT_CAL: begin
                    if (c0_init_calib_complete)
                        state <= IDLE;
                end
                IDLE: begin
                    if (!c0_init_calib_complete) begin
                        state <= WAIT_CAL;
                    end else if (!fifo_empty) begin
                        app.app_en       <= 1'b1;
                        app.app_wdf_wren <= 1'b1;
                        app.app_addr     <= addr_q;
                        app.app_wdf_data <= fifo_data[head_idx];
                        app.app_wdf_mask <= fifo_mask[head_idx];
                        state            <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (app.app_rdy)
                        app.app_en <= 1'b0;
                    if (app.app_wdf_rdy)
                        app.app_wdf_wren <= 1'b0;
                    if (word_done) begin
                        rd_ptr        <= rd_ptr + (PTR_W+1)'(1);
                        addr_q        <= addr_next;
                        words_written <= words_written + 32'd1;
                        // Later assignments override the drops above for back-to-back issue.
                        if (c0_init_calib_complete && fifo_count > (PTR_W+1)'(1)) begin
                            app.app_en       <= 1'b1;
                            app.app_wdf_wren <= 1'b1;
                            app.app_addr     <= addr_next;
                            app.app_wdf_data <= fifo_data[next_idx];
                            app.app_wdf_mask <= fifo_mask[next_idx];
                        end else begin
                            state <= c0_init_calib_complete ? IDLE : WAIT_CAL;
                        end
                    end
                end
                default: state <= WAIT_CAL;
            endcase
        end
    end

`ifdef DDR_WR_PERF_CNT_EN
    always_ff @(posedge ui_clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cmd_cycles  <= '0;
            stall_data_cycles <= '0;
        end else begin
            if (app.app_en && !app.app_rdy && !(&stall_cmd_cycles))
                stall_cmd_cycles <= stall_cmd_cycles + 32'd1;
            if (app.app_wdf_wren && !app.app_wdf_rdy && !(&stall_data_cycles))
                stall_data_cycles <= stall_data_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ddr_app_wr_packer.sv
// Directed bench for ddr_app_wr_packer with a simple MIG-side monitor.
module tb_ddr_app_wr_packer;
    logic         ui_clk;
    logic         rst_n;
    logic [127:0] din;
    logic         wr_en;
    logic         flush;
    logic         din_full;
    logic         calib;
    logic [31:0]  words_written;
    logic         overflow;
`ifdef DDR_WR_PERF_CNT_EN
    logic [31:0]  stall_cmd_cycles;
    logic [31:0]  stall_data_cycles;
`endif

    ddr_app_wr_packer_if #(.ADDR_W(28)) app_if ();

    ddr_app_wr_packer #(.ADDR_W(28), .ADDR_STEP(8), .FIFO_DEPTH(4)) dut (
        .ui_clk                 (ui_clk),
        .rst_n                  (rst_n),
        .din                    (din),
        .wr_en                  (wr_en),
        .flush                  (flush),
        .din_full               (din_full),
        .c0_init_calib_complete (calib),
        .app                    (app_if),
        .words_written          (words_written),
        .overflow               (overflow)
`ifdef DDR_WR_PERF_CNT_EN
        ,
        .stall_cmd_cycles       (stall_cmd_cycles),
        .stall_data_cycles      (stall_data_cycles)
`endif
    );

    initial begin
        ui_clk = 1'b0;
        forever #5 ui_clk = ~ui_clk;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [27:0]  cmd_q [$];
    logic [511:0] dat_q [$];
    logic [63:0]  msk_q [$];
    logic         en_seen;
    logic         cmd_stall, dat_stall;
    logic [27:0]  hold_addr;
    logic [511:0] hold_data;
    logic [63:0]  hold_mask;

    // Negedge monitor: values here are exactly what the controller sees at the next posedge.
    always @(negedge ui_clk) begin
        if (!rst_n) begin
            cmd_stall = 1'b0;
            dat_stall = 1'b0;
        end else begin
            if (app_if.app_en)
                en_seen = 1'b1;
            if (cmd_stall && app_if.app_en)
                check("addr_stable", app_if.app_addr, hold_addr);
            if (dat_stall && app_if.app_wdf_wren) begin
                check("data_stable", app_if.app_wdf_data, hold_data);
                check("mask_stable", app_if.app_wdf_mask, hold_mask);
            end
            if (app_if.app_en && app_if.app_rdy) begin
                cmd_q.push_back(app_if.app_addr);
                check("app_cmd", app_if.app_cmd, 3'b000);
            end
            if (app_if.app_wdf_wren && app_if.app_wdf_rdy) begin
                dat_q.push_back(app_if.app_wdf_data);
                msk_q.push_back(app_if.app_wdf_mask);
                check("wdf_end", app_if.app_wdf_end, 1'b1);
            end
            cmd_stall = app_if.app_en & ~app_if.app_rdy;
            dat_stall = app_if.app_wdf_wren & ~app_if.app_wdf_rdy;
            hold_addr = app_if.app_addr;
            hold_data = app_if.app_wdf_data;
            hold_mask = app_if.app_wdf_mask;
        end
    end

    task automatic tick();
        @(posedge ui_clk);
        #1;
    endtask

    task automatic clear_q();
        cmd_q.delete();
        dat_q.delete();
        msk_q.delete();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        wr_en = 1'b0;
        flush = 1'b0;
        repeat (3) tick();
        clear_q();
        rst_n = 1'b1;
        tick();
    endtask

    // Beat held for one cycle, regardless of back-pressure.
    task automatic drive(input logic [127:0] d);
        wr_en = 1'b1;
        din   = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic send(input logic [127:0] d);
        int guard = 0;
        while (din_full && guard < 500) begin
            tick();
            guard++;
        end
        if (guard >= 500)
            check("din_full_timeout", din_full, 1'b0);
        drive(d);
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    task automatic wait_ww(input string tag, input int n);
        int guard = 0;
        while (words_written != 32'(n) && guard < 3000) begin
            tick();
            guard++;
        end
        check(tag, words_written, 32'(n));
    endtask

    function automatic logic [511:0] ramp_word(input int k);
        return {128'(4*k+4), 128'(4*k+3), 128'(4*k+2), 128'(4*k+1)};
    endfunction

    int first_full;

    initial begin
        rst_n = 1'b0;
        din   = '0;
        wr_en = 1'b0;
        flush = 1'b0;
        calib = 1'b0;
        app_if.app_rdy     = 1'b1;
        app_if.app_wdf_rdy = 1'b1;
        en_seen = 1'b0;
        repeat (3) tick();

        // Reset state
        check("rst_app_en", app_if.app_en, 1'b0);
        check("rst_wren", app_if.app_wdf_wren, 1'b0);
        check("rst_addr", app_if.app_addr, 28'd0);
        check("rst_data", app_if.app_wdf_data, 512'd0);
        check("rst_din_full", din_full, 1'b0);
        check("rst_ww", words_written, 32'd0);
        check("rst_overflow", overflow, 1'b0);
        rst_n = 1'b1;
        tick();

        // Calibration held low: words buffer but are not issued
        for (int i = 0; i < 8; i++) send(128'(16 + i));
        en_seen = 1'b0;
        repeat (200) tick();
        check("nocal_en_seen", en_seen, 1'b0);
        check("nocal_cmds", cmd_q.size(), 0);
        check("nocal_din_full", din_full, 1'b0);
        calib = 1'b1;
        wait_ww("cal_ww", 2);
        check("cal_ncmd", cmd_q.size(), 2);
        check("cal_addr0", cmd_q[0], 28'd0);
        check("cal_addr1", cmd_q[1], 28'd8);
        check("cal_data0", dat_q[0], {128'h13, 128'h12, 128'h11, 128'h10});
        check("cal_data1", dat_q[1], {128'h17, 128'h16, 128'h15, 128'h14});

        // Ramp 1..500 with both ready lines high
        do_reset();
        for (int i = 1; i <= 500; i++) send(128'(i));
        wait_ww("ramp_ww", 125);
        repeat (5) tick();
        check("ramp_ncmd", cmd_q.size(), 125);
        check("ramp_ndat", dat_q.size(), 125);
        for (int k = 0; k < 125; k++) begin
            check("ramp_addr", cmd_q[k], 28'(8*k));
            check("ramp_data", dat_q[k], ramp_word(k));
            check("ramp_mask", msk_q[k], 64'd0);
        end

        // Flush of a partial word, no-op flush, flush together with a beat
        do_reset();
        for (int i = 1; i <= 6; i++) send(128'(i));
        pulse_flush();
        wait_ww("flush_ww", 2);
        check("flush_mask0", msk_q[0], 64'd0);
        check("flush_data1", dat_q[1], {256'd0, 128'd6, 128'd5});
        check("flush_mask1", msk_q[1], 64'hFFFFFFFF_00000000);
        pulse_flush();
        repeat (10) tick();
        check("flush_noop_ww", words_written, 32'd2);
        check("flush_noop_ncmd", cmd_q.size(), 2);
        wr_en = 1'b1;
        din   = 128'd7;
        flush = 1'b1;
        tick();
        wr_en = 1'b0;
        flush = 1'b0;
        wait_ww("flush_beat_ww", 3);
        check("flush_beat_addr", cmd_q[2], 28'd16);
        check("flush_beat_data", dat_q[2], {384'd0, 128'd7});
        check("flush_beat_mask", msk_q[2], 64'hFFFFFFFF_FFFF0000);

        // Command ack late, then data ack late
        do_reset();
        app_if.app_rdy = 1'b0;
        for (int i = 0; i < 4; i++) send(128'(32'hA0 + i));
        repeat (12) tick();
        check("cstall_ww", words_written, 32'd0);
        check("cstall_ncmd", cmd_q.size(), 0);
        check("cstall_ndat", dat_q.size(), 1);
        check("cstall_en", app_if.app_en, 1'b1);
        app_if.app_rdy = 1'b1;
        wait_ww("cstall_done", 1);
        app_if.app_wdf_rdy = 1'b0;
        for (int i = 0; i < 4; i++) send(128'(32'hB0 + i));
        repeat (12) tick();
        check("dstall_ww", words_written, 32'd1);
        check("dstall_ncmd", cmd_q.size(), 2);
        check("dstall_ndat", dat_q.size(), 1);
        check("dstall_wren", app_if.app_wdf_wren, 1'b1);
        app_if.app_wdf_rdy = 1'b1;
        wait_ww("dstall_done", 2);
        repeat (5) tick();
        check("stall_ncmd", cmd_q.size(), 2);
        check("stall_ndat", dat_q.size(), 2);
        check("stall_addr1", cmd_q[1], 28'd8);
        check("stall_data0", dat_q[0], {128'hA3, 128'hA2, 128'hA1, 128'hA0});
        check("stall_data1", dat_q[1], {128'hB3, 128'hB2, 128'hB1, 128'hB0});

        // Back-pressure and overflow with the command channel blocked
        do_reset();
        app_if.app_rdy = 1'b0;
        first_full = 0;
        for (int i = 1; i <= 24; i++) begin
            if (din_full && first_full == 0) first_full = i;
            if (i == 20) check("ovf_before_drop", overflow, 1'b0);
            drive(128'(i));
        end
        check("ovf_first_full", first_full, 20);
        check("ovf_flag", overflow, 1'b1);
        check("ovf_din_full", din_full, 1'b1);
        check("ovf_ww", words_written, 32'd0);

        // Reset while a word is being issued
        check("midrst_en_before", app_if.app_en, 1'b1);
        rst_n = 1'b0;
        #1;
        check("midrst_en", app_if.app_en, 1'b0);
        check("midrst_wren", app_if.app_wdf_wren, 1'b0);
        check("midrst_data", app_if.app_wdf_data, 512'd0);
        check("midrst_ovf", overflow, 1'b0);
        check("midrst_din_full", din_full, 1'b0);
        repeat (2) tick();
        clear_q();
        app_if.app_rdy = 1'b1;
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) send(128'(32'hC0 + i));
        wait_ww("midrst_ww", 1);
        check("midrst_addr", cmd_q[0], 28'd0);
        check("midrst_word", dat_q[0], {128'hC3, 128'hC2, 128'hC1, 128'hC0});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
